reg_file: RTL



---
 rtl/cpu_defs.sv | 16 +
 rtl/reg_file_if.sv | 33 +++
 rtl/reg_read_port.sv | 30 +++
 rtl/reg_file.sv | 79 +++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU constants: datapath width, register indices.
// Used by reg_file and its read ports.
package cpu_defs;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] ridx_t;

endpackage

// File: rtl/reg_file_if.sv
// Register file access bundle: write port, two read ports,
// debug read port and write counter.
interface reg_file_if #(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int ADDR_W = cpu_defs::REG_ADDR_W
);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [DATA_W-1:0] wr_count;

  modport master (
    output we, waddr, wdata,
    output raddr1, raddr2, dbg_addr,
    input  rdata1, rdata2, dbg_data,
    input  wr_count
  );

  modport slave (
    input  we, waddr, wdata,
    input  raddr1, raddr2, dbg_addr,
    output rdata1, rdata2, dbg_data,
    output wr_count
  );

endinterface

// File: rtl/reg_read_port.sv
// One combinational register read port: r0 forced to zero,
// optional write-through forwarding when REG_BYPASS_EN is defined.
module reg_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_stored,
`ifdef REG_BYPASS_EN
  input  logic              i_wr_fire,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
`endif
  output logic [DATA_W-1:0] o_data
);

  import cpu_defs::*;

  logic [DATA_W-1:0] w_sel;

  always_comb begin
    w_sel = i_stored;
`ifdef REG_BYPASS_EN
    if (i_wr_fire && (i_addr == i_waddr))
      w_sel = i_wdata;
`endif
    o_data = (i_addr == REG_ZERO) ? '0 : w_sel;
  end

endmodule

// File: rtl/reg_file.sv
// 32x32 integer register file, 2 read + 1 debug read, 1 write.
// Build option: REG_BYPASS_EN enables same-cycle write forwarding.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  import cpu_defs::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] r_wr_count;
  logic              w_wr_fire;

  // Reset outranks a write presented on the same edge.
  assign w_wr_fire = bus.we && !rst &&
                     (bus.waddr != REG_ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= '0;
      r_wr_count <= '0;
    end else if (w_wr_fire) begin
      r_regs[bus.waddr] <= bus.wdata;
      r_wr_count        <= r_wr_count + 1'b1;
    end
  end

  assign bus.wr_count = r_wr_count;

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd1 (
    .i_addr    (bus.raddr1),
    .i_stored  (r_regs[bus.raddr1]),
`ifdef REG_BYPASS_EN
    .i_wr_fire (w_wr_fire),
    .i_waddr   (bus.waddr),
    .i_wdata   (bus.wdata),
`endif
    .o_data    (bus.rdata1)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd2 (
    .i_addr    (bus.raddr2),
    .i_stored  (r_regs[bus.raddr2]),
`ifdef REG_BYPASS_EN
    .i_wr_fire (w_wr_fire),
    .i_waddr   (bus.waddr),
    .i_wdata   (bus.wdata),
`endif
    .o_data    (bus.rdata2)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dbg (
    .i_addr    (bus.dbg_addr),
    .i_stored  (r_regs[bus.dbg_addr]),
`ifdef REG_BYPASS_EN
    .i_wr_fire (w_wr_fire),
    .i_waddr   (bus.waddr),
    .i_wdata   (bus.wdata),
`endif
    .o_data    (bus.dbg_data)
  );

endmodule
